conv_stream_driver: RTL

Host-side counterpart of the convolution stream interface: buffers one input vector of SIZE_X signed samples, transmits it on the x valid/ready channel into a convolution block, then receives the SIZE_X-SIZE_F+1 results on the y valid/ready channel into a result buffer that the host reads back. It sits between the host or testbench loader and the conv module's x_data/x_valid/x_ready and y_data/y_valid/y_ready ports, acting as x transmitter and y receiver.

---
 rtl/conv_stream_if.sv | 26 ++
 rtl/conv_stream_driver.sv | 102 ++++++++++
 2 files changed

// File: rtl/conv_stream_if.sv
// conv_stream_if: bundle of the load, start, x/y stream, result-read and status signals of conv_stream_driver
// master: driver view (drives load_ready, x_*, y_ready, res_data, busy, done); slave: host/conv view.
interface conv_stream_if #(
  parameter int T = 16,
  parameter int SIZE_X = 16,
  parameter int SIZE_F = 4
);
  localparam int AW = $clog2(SIZE_X - SIZE_F + 1);
  logic [T-1:0] load_data;
  logic load_valid, load_ready, start;
  logic [T-1:0] x_data;
  logic x_valid, x_ready;
  logic [T-1:0] y_data;
  logic y_valid, y_ready;
  logic [AW-1:0] res_addr;
  logic [T-1:0] res_data;
  logic busy, done;
  modport master (
    input  load_data, load_valid, start, x_ready, y_data, y_valid, res_addr,
    output load_ready, x_data, x_valid, y_ready, res_data, busy, done
  );
  modport slave (
    output load_data, load_valid, start, x_ready, y_data, y_valid, res_addr,
    input  load_ready, x_data, x_valid, y_ready, res_data, busy, done
  );
endinterface

// File: rtl/conv_stream_driver.sv
// conv_stream_driver: buffers SIZE_X samples, streams them out on x, collects SIZE_X-SIZE_F+1 results from y
// Ports: clk, reset (async active-high); bus (conv_stream_if.master) with load channel, start,
// x stream out, y stream in, registered result read port, busy/done status.
module conv_stream_driver #(
  parameter int T = 16,
  parameter int SIZE_X = 16,
  parameter int SIZE_F = 4
) (
  input logic clk,
  input logic reset,
  conv_stream_if.master bus
);
  localparam int CP = SIZE_X - SIZE_F + 1;
  localparam int AW = $clog2(CP);
  localparam int IW = $clog2(SIZE_X);
  localparam int CW = $clog2(SIZE_X + 1);
  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;
  state_t r_state;
  logic [T-1:0] r_buf [2**IW];
  logic [T-1:0] r_res [2**AW];
  logic [CW-1:0] r_load_cnt, r_send_cnt, r_y_cnt;
  logic r_load_ready, r_x_valid, r_y_ready, r_busy, r_done;
  logic [T-1:0] r_x_data, r_res_data;
  logic [CW-1:0] w_send_nxt;
  logic w_load_hs, w_x_hs, w_y_hs;
  assign w_send_nxt = r_send_cnt + CW'(1);
  assign w_load_hs = r_load_ready & bus.load_valid;
  assign w_x_hs = r_x_valid & bus.x_ready;
  assign w_y_hs = r_y_ready & bus.y_valid;
  assign bus.load_ready = r_load_ready;
  assign bus.x_valid = r_x_valid;
  assign bus.x_data = r_x_data;
  assign bus.y_ready = r_y_ready;
  assign bus.res_data = r_res_data;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  // Storage is not reset; load_ready reads 1 during reset, so loads are masked explicitly.
  always_ff @(posedge clk) begin
    if (w_load_hs && !reset) r_buf[r_load_cnt[IW-1:0]] <= bus.load_data;
    if (w_y_hs) r_res[r_y_cnt[AW-1:0]] <= bus.y_data;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_load_cnt <= '0;
      r_send_cnt <= '0;
      r_y_cnt <= '0;
      r_load_ready <= 1'b1;
      r_x_valid <= 1'b0;
      r_x_data <= '0;
      r_y_ready <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_res_data <= '0;
    end else begin
      r_res_data <= r_res[bus.res_addr];
      case (r_state)
        IDLE:
          if (w_load_hs) begin
            r_load_cnt <= r_load_cnt + CW'(1);
            r_load_ready <= r_load_cnt != CW'(SIZE_X - 1);
          end else if (bus.start && r_load_cnt == CW'(SIZE_X)) begin
            r_state <= SEND;
            r_send_cnt <= '0;
            r_x_valid <= 1'b1;
            r_x_data <= r_buf[0];
            r_busy <= 1'b1;
          end
        SEND:
          // Next sample is preloaded on every handshake so back-to-back transfers have no bubble.
          if (w_x_hs) begin
            r_send_cnt <= w_send_nxt;
            r_x_data <= r_buf[w_send_nxt[IW-1:0]];
            if (w_send_nxt == CW'(SIZE_X)) begin
              r_state <= RECV;
              r_x_valid <= 1'b0;
              r_y_ready <= 1'b1;
              r_y_cnt <= '0;
            end
          end
        RECV:
          if (w_y_hs) begin
            r_y_cnt <= r_y_cnt + CW'(1);
            if (r_y_cnt == CW'(CP - 1)) begin
              r_state <= DONE;
              r_y_ready <= 1'b0;
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end
          end
        default:
          if (bus.start) begin
            r_state <= IDLE;
            r_done <= 1'b0;
            r_load_ready <= 1'b1;
            r_load_cnt <= '0;
            r_send_cnt <= '0;
            r_y_cnt <= '0;
          end
      endcase
    end
endmodule
